pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package ctrl_pkg;

  // Controller state; the 2-bit encoding is visible on ctrl_state.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_BRFLUSH = 2'd2,
    ST_MEMWAIT = 2'd3
  } ctrl_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int          STALL_CNT_W     = 32;
  localparam int          FLUSH_CNT_W     = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, hold/flush/status out.
interface pipe_hazard_ctrl_if;
  import ctrl_pkg::*;

  logic [4:0]             rs1_idx_fromIF;
  logic [4:0]             rs2_idx_fromIF;
  logic [4:0]             rd_idx_fromID;
  logic                   mem_rd_fromID;
  logic                   br_taken;
  logic                   dmem_req;
  logic                   dmem_ready;
  logic                   imem_ready;
  logic                   pc_hold;
  logic                   ifid_hold;
  logic                   idex_hold;
  logic                   exmem_hold;
  logic                   flush_IF;
  logic                   flush_ID;
  logic [1:0]             ctrl_state;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   mem_timeout;

  // Pipeline side: drives status, consumes controls.
  modport master (
    output rs1_idx_fromIF, rs2_idx_fromIF, rd_idx_fromID, mem_rd_fromID,
           br_taken, dmem_req, dmem_ready, imem_ready,
    input  pc_hold, ifid_hold, idex_hold, exmem_hold, flush_IF, flush_ID,
           ctrl_state, stall_cnt, flush_cnt, mem_timeout
  );

  // Controller side.
  modport slave (
    input  rs1_idx_fromIF, rs2_idx_fromIF, rd_idx_fromID, mem_rd_fromID,
           br_taken, dmem_req, dmem_ready, imem_ready,
    output pc_hold, ifid_hold, idex_hold, exmem_hold, flush_IF, flush_ID,
           ctrl_state, stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Step by one when enabled, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decodes hold/flush controls from the current
// state and pipeline status, and tracks stall/redirect/timeout statistics.
module pipe_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hif
);

  // Wide enough to hold MEM_TIMEOUT itself; the counter parks there.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              timeout_q, timeout_d;

  logic mem_wait, load_use;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold, flush_if, flush_id;
  logic redirect;

  // A pending data access not yet acknowledged stalls the whole pipe.
  assign mem_wait = hif.dmem_req & ~hif.dmem_ready;

  // Register 0 is hard-wired, so a load into it can never be a hazard.
  assign load_use = hif.mem_rd_fromID && (hif.rd_idx_fromID != 5'd0) &&
                    ((hif.rd_idx_fromID == hif.rs1_idx_fromIF) ||
                     (hif.rd_idx_fromID == hif.rs2_idx_fromIF));

  // Priority decode: memory wait > redirect > load-use > fetch wait.
  // A released MEMWAIT behaves like RUN; LDUSE/BRFLUSH mask their own event.
  always_comb begin
    state_d    = ST_RUN;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    redirect   = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (mem_wait) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      state_d    = ST_MEMWAIT;
    end else if (hif.br_taken && (state_q != ST_BRFLUSH)) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
      redirect = 1'b1;
      state_d  = ST_BRFLUSH;
    end else if (load_use && (state_q != ST_LDUSE)) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      flush_id  = 1'b1;
      state_d   = ST_LDUSE;
    end else if (!hif.imem_ready) begin
      // Fetch bubble: the one-cycle states still fall back to RUN.
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      flush_id  = 1'b1;
      state_d   = ST_RUN;
    end
  end

  // Consecutive memory-wait cycles; timeout is sticky until reset.
  always_comb begin
    wait_inc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (mem_wait) begin
      wait_d = wait_inc;
      if (wait_inc >= WAIT_MAX) timeout_d = 1'b1;
    end
  end

  // State, wait counter and timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pc_hold),
    .cnt (hif.stall_cnt)
  );

  sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (redirect),
    .cnt (hif.flush_cnt)
  );

  assign hif.pc_hold     = pc_hold;
  assign hif.ifid_hold   = ifid_hold;
  assign hif.idex_hold   = idex_hold;
  assign hif.exmem_hold  = exmem_hold;
  assign hif.flush_IF    = flush_if;
  assign hif.flush_ID    = flush_id;
  assign hif.ctrl_state  = state_q;
  assign hif.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level reference model,
// plus directed scenarios for load-use, redirect, memory wait and reset.
module tb_pipe_hazard_ctrl;

  localparam int MT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hif();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: state as a number 0..3, counters as plain integers.
  int      m_state;
  longint  m_stall;
  int      m_flush;
  int      m_wait;
  bit      m_to;
  bit [5:0] e_ho;   // {pc, ifid, idex, exmem, flush_IF, flush_ID}
  int      e_nxt;
  bit      e_redir;
  bit      e_mw;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
  endtask

  // Expected controls for this cycle, straight from the priority rules.
  task automatic model_eval();
    bit lu;
    e_mw = hif.dmem_req && !hif.dmem_ready;
    lu = hif.mem_rd_fromID && (hif.rd_idx_fromID != 0) &&
         ((hif.rd_idx_fromID == hif.rs1_idx_fromIF) || (hif.rd_idx_fromID == hif.rs2_idx_fromIF));
    e_ho = 6'b0; e_nxt = 0; e_redir = 1'b0;
    if (e_mw) begin
      e_ho = 6'b111100; e_nxt = 3;
    end else if (hif.br_taken && m_state != 2) begin
      e_ho = 6'b000011; e_nxt = 2; e_redir = 1'b1;
    end else if (lu && m_state != 1) begin
      e_ho = 6'b110001; e_nxt = 1;
    end else if (!hif.imem_ready) begin
      e_ho = 6'b110001; e_nxt = 0;
    end
  endtask

  function automatic logic [31:0] dut_ho();
    return 32'({hif.pc_hold, hif.ifid_hold, hif.idex_hold, hif.exmem_hold,
                hif.flush_IF, hif.flush_ID});
  endfunction

  task automatic chk_regs(input string pfx);
    chk({pfx, "_state"},   32'(hif.ctrl_state),  32'(m_state));
    chk({pfx, "_stall"},   hif.stall_cnt,        32'(m_stall));
    chk({pfx, "_flush"},   32'(hif.flush_cnt),   32'(m_flush));
    chk({pfx, "_timeout"}, 32'(hif.mem_timeout), 32'(m_to));
  endtask

  // Called at a negedge with inputs already applied; returns at next negedge.
  task automatic step();
    #1;
    model_eval();
    chk("hold_flush", dut_ho(), 32'(e_ho));
    chk_regs("cyc");
    @(posedge clk);
    if (e_ho[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (e_redir && m_flush < 16'hFFFF) m_flush++;
    if (e_mw) begin
      m_wait++;
      if (m_wait >= MT) m_to = 1'b1;
    end else begin
      m_wait = 0;
    end
    m_state = e_nxt;
    @(negedge clk);
  endtask

  task automatic set_in(input int rs1, input int rs2, input int rd, input bit mr,
                        input bit br, input bit dq, input bit dr, input bit ir);
    hif.rs1_idx_fromIF = 5'(rs1);
    hif.rs2_idx_fromIF = 5'(rs2);
    hif.rd_idx_fromID  = 5'(rd);
    hif.mem_rd_fromID  = mr;
    hif.br_taken       = br;
    hif.dmem_req       = dq;
    hif.dmem_ready     = dr;
    hif.imem_ready     = ir;
  endtask

  task automatic set_idle();
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // Asynchronous reset pulse launched between edges; outputs must clear at once.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_ho", dut_ho(), 32'd0);
    chk_regs("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(5, 5, 5, 1, 1, 1, 0, 0);   // events asserted: must be masked in reset
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_ho", dut_ho(), 32'd0);
    chk_regs("por");
    rst = 1'b0;
    set_idle();

    // Load into x5 with rs1=5: one-cycle load-use stall.
    set_in(5, 0, 5, 1, 0, 0, 1, 1);
    step();
    chk("lu_state1", 32'(hif.ctrl_state), 32'd1);
    step();                            // LDUSE masks the same hazard
    chk("lu_state0", 32'(hif.ctrl_state), 32'd0);
    chk("lu_stall",  hif.stall_cnt, 32'd1);

    // Load into x0 never stalls.
    async_reset();
    set_in(0, 0, 0, 1, 0, 0, 1, 1);
    step();
    chk("x0_state", 32'(hif.ctrl_state), 32'd0);
    chk("x0_stall", hif.stall_cnt, 32'd0);

    // Single-cycle redirect, then a branch held for two cycles.
    async_reset();
    set_in(0, 0, 0, 0, 1, 0, 1, 1);
    step();
    chk("br_state", 32'(hif.ctrl_state), 32'd2);
    set_idle();
    step();
    chk("br_cnt1", 32'(hif.flush_cnt), 32'd1);
    async_reset();
    set_in(0, 0, 0, 0, 1, 0, 1, 1);
    step();
    step();
    chk("br_held_cnt", 32'(hif.flush_cnt), 32'd1);

    // Memory wait outranks a redirect; redirect fires once memory is done.
    async_reset();
    set_in(0, 0, 0, 0, 1, 1, 0, 1);
    repeat (3) step();
    chk("mw_state", 32'(hif.ctrl_state), 32'd3);
    set_in(0, 0, 0, 0, 1, 1, 1, 1);
    #1;
    chk("mw_release_ho", dut_ho(), 32'b000011);
    #(-1 + 1);
    step();
    chk("mw_stall", hif.stall_cnt, 32'd3);
    chk("mw_flush", 32'(hif.flush_cnt), 32'd1);

    // Timeout after the MT-th consecutive wait cycle, sticky until reset.
    async_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("to_seq", 32'(hif.mem_timeout), 32'(k >= MT));
    end
    set_idle();
    repeat (3) step();
    chk("to_sticky", 32'(hif.mem_timeout), 32'd1);

    // Reset in the middle of MEMWAIT.
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    repeat (2) step();
    async_reset();
    chk("mid_mw_timeout", 32'(hif.mem_timeout), 32'd0);
    set_idle();
    step();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
